test_port_write_filter: RTL
===========================

// Module: test_port_write_filter
// PURPOSE
//  Sits between the CPU data-memory write interface and the result checker. Snoops committed
//  data writes, keeps only those to the test port, and buffers them in a small FIFO.
//  Replays each buffered write to the checker as a clean single-cycle wen pulse followed by
//  a guaranteed low gap, so D-cache stalls never present a write twice or back-to-back.
//  Also reports how many words were passed through and whether the end marker was seen.
// PARAMETERS
//  PORT_ADDR   30'h40        word address of the test port (r30 mapping)
//  BEGIN_SYM   32'h00000932  begin marker; writes before it are discarded
//  END_SYM     32'h00000D5D  end marker; writes after it are discarded
//  DEPTH_LOG2  3             FIFO depth = 2**DEPTH_LOG2 entries (32-bit data each)
//  GAP_CYCLES  1             minimum wen-low cycles after each output pulse (>=1)
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   asynchronous reset, active low
//  mem_addr   in   30  CPU data-memory word address
//  mem_wdata  in   32  CPU write data
//  mem_wen    in   1   CPU write enable (may be held high across stall cycles)
//  mem_stall  in   1   D-cache stall; a write commits only when mem_wen && !mem_stall
//  addr       out  30  to checker: PORT_ADDR while wen=1, else 0
//  data       out  32  to checker: replayed data while wen=1, else 0
//  wen        out  1   to checker: one-cycle write strobe
//  pass_cnt   out  16  number of words emitted on wen (saturates at 16'hFFFF)
//  overflow   out  1   sticky: a qualifying write was dropped because the FIFO was full
//  done       out  1   sticky: END_SYM has been emitted on the output side
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, ptrs 0, session=IDLE, out FSM=O_IDLE; addr=0, data=0,
//   wen=0, pass_cnt=0, overflow=0, done=0. Mid-operation reset discards FIFO contents.
//  Commit: commit = mem_wen && !mem_stall && mem_addr==PORT_ADDR. Held mem_wen across a stall
//   commits exactly once, in the first cycle mem_stall is low.
//  Session FSM (input side): S_IDLE -> S_ACTIVE on commit with data==BEGIN_SYM (pushed);
//   S_ACTIVE pushes every commit; commit of END_SYM is pushed and moves to S_CLOSED;
//   S_CLOSED ignores all commits. Commits in S_IDLE other than BEGIN_SYM are ignored.
//  FIFO: push on qualifying commit; pop when out FSM leaves O_IDLE. Push when full and no pop
//   in same cycle -> write dropped, overflow<=1. Push+pop same cycle when full -> both occur,
//   count unchanged. Pointers DEPTH_LOG2+1 bits, wrap naturally; empty=ptrs equal,
//   full=MSB differ & rest equal.
//  Output FSM: O_IDLE: if FIFO non-empty, pop head into out register, go O_DRIVE.
//   O_DRIVE (1 cycle): wen=1, addr=PORT_ADDR, data=head; pass_cnt+1 (saturating);
//   if data==END_SYM, done<=1; go O_GAP with gap counter=GAP_CYCLES.
//   O_GAP: wen=0, addr=0, data=0; decrement; at 1 return to O_IDLE.
//  Latency: commit at cycle T into empty FIFO -> wen=1 at cycle T+2 (push T, pop T+1).
//  Throughput: one output word per 1+GAP_CYCLES+1 cycles max; wen never high two
//   consecutive cycles.
//  Outputs are registered; addr/data are 0 whenever wen=0.
// TESTING
//  1. Reset mid-drain with 3 entries queued -> next cycle wen=0, pass_cnt=0, no later pulses.
//  2. Commit BEGIN_SYM then 0,1,1,2 one per cycle -> wen pulses 932h,0,1,1,2 in order,
//     first at T+2, each followed by >=1 low cycle; pass_cnt=5.
//  3. mem_wen=1 to PORT_ADDR data=5 with mem_stall=1 for 4 cycles then 0 -> exactly one
//     pulse data=5.
//  4. Writes to 30'h41 and test-port writes before BEGIN_SYM / after END_SYM -> no pulses;
//     done=1 after END_SYM pulse.
//  5. Burst of 12 commits with DEPTH_LOG2=3, GAP_CYCLES=3 -> overflow=1, emitted words are the
//     accepted prefix in order, none duplicated.
//  6. Push+pop in the same cycle with FIFO full -> no drop, overflow stays 0.

Source files
------------

// File: rtl/test_port_write_filter_if.sv
// Bus bundle between the CPU data-memory write port, the write filter and the result checker.
// The master side drives the CPU write and observes the replayed checker write.
interface test_port_write_filter_if;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic        mem_stall;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;

  modport master (
    output mem_addr, mem_wdata, mem_wen, mem_stall,
    input  addr, data, wen
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wen, mem_stall,
    output addr, data, wen
  );
endinterface

// File: rtl/test_port_write_filter.sv
// Snoops committed CPU writes to the test port between the begin and end markers and buffers
// them. Each buffered word is replayed as a single-cycle wen pulse followed by a low gap.
module test_port_write_filter #(
  parameter logic [29:0] PORT_ADDR  = 30'h40,
  parameter logic [31:0] BEGIN_SYM  = 32'h00000932,
  parameter logic [31:0] END_SYM    = 32'h00000D5D,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  test_port_write_filter_if.slave   bus,
  output logic [15:0]               pass_cnt,
  output logic                      overflow,
  output logic                      done
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned GapW  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef logic [DEPTH_LOG2:0] ptr_t;

  typedef enum logic [1:0] {SessIdle, SessActive, SessClosed} sess_e;
  typedef enum logic [1:0] {OutIdle, OutDrive, OutGap} out_e;

  sess_e sess_q, sess_d;
  out_e  out_q, out_d;

  logic [31:0]     mem_q [Depth];
  ptr_t            wptr_q, rptr_q;
  logic [29:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            wen_q, wen_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            ovf_q, done_q, done_d;

  logic commit, push_req, push, pop, drop, empty, full;

  assign commit = bus.mem_wen && !bus.mem_stall && (bus.mem_addr == PORT_ADDR);
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                  (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign pop    = (out_q == OutIdle) && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push   = push_req && (!full || pop);
  assign drop   = push_req && full && !pop;

  // Session tracking: only the begin..end window is forwarded.
  always_comb begin
    sess_d   = sess_q;
    push_req = 1'b0;
    unique case (sess_q)
      SessIdle: begin
        if (commit && bus.mem_wdata == BEGIN_SYM) begin
          push_req = 1'b1;
          sess_d   = SessActive;
        end
      end
      SessActive: begin
        if (commit) begin
          push_req = 1'b1;
          if (bus.mem_wdata == END_SYM) sess_d = SessClosed;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    wen_d  = 1'b0;
    addr_d = '0;
    data_d = '0;
    gap_d  = gap_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    unique case (out_q)
      OutIdle: begin
        if (!empty) begin
          wen_d  = 1'b1;
          addr_d = PORT_ADDR;
          data_d = mem_q[rptr_q[DEPTH_LOG2-1:0]];
          out_d  = OutDrive;
        end
      end
      OutDrive: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (data_q == END_SYM) done_d = 1'b1;
        gap_d = GapW'(GAP_CYCLES);
        out_d = OutGap;
      end
      OutGap: begin
        if (gap_q <= GapW'(1)) out_d = OutIdle;
        else                   gap_d = gap_q - GapW'(1);
      end
      default: out_d = OutIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sess_q <= SessIdle;
      out_q  <= OutIdle;
      wptr_q <= '0;
      rptr_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wen_q  <= 1'b0;
      gap_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sess_q <= sess_d;
      out_q  <= out_d;
      if (push) wptr_q <= wptr_q + ptr_t'(1);
      if (pop)  rptr_q <= rptr_q + ptr_t'(1);
      addr_q <= addr_d;
      data_q <= data_d;
      wen_q  <= wen_d;
      gap_q  <= gap_d;
      cnt_q  <= cnt_d;
      if (drop) ovf_q <= 1'b1;
      done_q <= done_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= bus.mem_wdata;
  end

  assign bus.addr = addr_q;
  assign bus.data = data_q;
  assign bus.wen  = wen_q;
  assign pass_cnt = cnt_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule
